// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage register with a valid/ready handshake on both sides.
// A one-entry skid buffer keeps upstream ready fully registered, so there is
// no combinational path from out_ready to in_ready. Flush is synchronous.
// Bubbles zero the control fields and keep the data fields.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_BITS     = 32,
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned WB_BITS       = 2,
  parameter int unsigned M_BITS        = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic [WB_BITS-1:0]       WB_in,
  input  logic [M_BITS-1:0]        M_in,
  input  logic [DATA_BITS-1:0]     ALU_result_in,
  input  logic [DATA_BITS-1:0]     ALU_src2_in,
  input  logic                     ALU_zero_in,
  input  logic [DATA_BITS-1:0]     PC_in,
  input  logic [REG_ADDR_BITS-1:0] REG_dst_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WB_BITS-1:0]       WB_out,
  output logic [M_BITS-1:0]        M_out,
  output logic [DATA_BITS-1:0]     ALU_result_out,
  output logic [DATA_BITS-1:0]     ALU_src2_out,
  output logic                     ALU_zero_out,
  output logic [DATA_BITS-1:0]     PC_out,
  output logic [REG_ADDR_BITS-1:0] REG_dst_out,
  output logic                     skid_full
);

  typedef struct packed {
    logic [WB_BITS-1:0]       wb;
    logic [M_BITS-1:0]        m;
    logic [DATA_BITS-1:0]     alu_result;
    logic [DATA_BITS-1:0]     alu_src2;
    logic                     alu_zero;
    logic [DATA_BITS-1:0]     pc;
    logic [REG_ADDR_BITS-1:0] reg_dst;
  } stage_t;

  stage_t in_pkt;
  stage_t m_q, m_d;
  stage_t s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   ready_q, ready_d;
  logic   in_fire;
  logic   m_free;

  // Gather the input fields into one payload
  assign in_pkt = '{wb:         WB_in,
                    m:          M_in,
                    alu_result: ALU_result_in,
                    alu_src2:   ALU_src2_in,
                    alu_zero:   ALU_zero_in,
                    pc:         PC_in,
                    reg_dst:    REG_dst_in};

  assign in_fire = in_valid && ready_q;
  assign m_free  = !m_valid_q || out_ready;

  // Next-state for main and skid entries; flush overrides everything
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_d.wb    = '0;
      m_d.m     = '0;
      s_d.wb    = '0;
      s_d.m     = '0;
    end else if (m_free) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        if (in_fire) begin
          s_d       = in_pkt;
          s_valid_d = 1'b1;
        end else begin
          s_valid_d = 1'b0;
          s_d.wb    = '0;
          s_d.m     = '0;
        end
      end else if (in_fire) begin
        m_d       = in_pkt;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
        m_d.wb    = '0;
        m_d.m     = '0;
      end
    end else if (in_fire) begin
      s_d       = in_pkt;
      s_valid_d = 1'b1;
    end
    ready_d = !s_valid_d;
  end

  // Stage state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready       = ready_q;
  assign out_valid      = m_valid_q;
  assign skid_full      = s_valid_q;
  assign WB_out         = m_q.wb;
  assign M_out          = m_q.m;
  assign ALU_result_out = m_q.alu_result;
  assign ALU_src2_out   = m_q.alu_src2;
  assign ALU_zero_out   = m_q.alu_zero;
  assign PC_out         = m_q.pc;
  assign REG_dst_out    = m_q.reg_dst;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline stage register, the successor to the fixed 32-bit EX/MEM latch. Adds a valid/ready handshake on both sides, a one-entry skid buffer so upstream ready is fully registered, synchronous flush, and bubble insertion that zeroes control fields. Sits between the ALU stage and the data-memory stage of the 5-stage core.

Parameters:
DATA_BITS, 32, width of ALU_result, ALU_src2 and PC fields
REG_ADDR_BITS, 5, width of destination register index
WB_BITS, 2, write-back control width {reg write, mem to reg}
M_BITS, 3, memory control width {branch, mem read, mem write}

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  EX stage presents a valid instruction
in_ready  output  1  block can accept input this cycle
flush  input  1  synchronous kill of all held instructions
WB_in  input  WB_BITS  write-back control
M_in  input  M_BITS  memory control
ALU_result_in  input  DATA_BITS  ALU result
ALU_src2_in  input  DATA_BITS  store data
ALU_zero_in  input  1  ALU zero flag
PC_in  input  DATA_BITS  branch target / PC
REG_dst_in  input  REG_ADDR_BITS  destination register
out_valid  output  1  MEM-stage fields are valid
out_ready  input  1  MEM stage consumes output this cycle
WB_out, M_out, ALU_result_out, ALU_src2_out, ALU_zero_out, PC_out, REG_dst_out  output  same widths as inputs  registered stage fields
skid_full  output  1  skid entry occupied (debug/perf counter tap)

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, skid_full=0, in_ready=1; all *_out fields and skid contents = 0. Takes effect immediately, independent of clk; any in-flight instruction lost.
- Storage: main register M (drives *_out, out_valid) and skid register S (skid_full = S valid). in_ready = !skid_full, driven directly from a flop, no combinational path from out_ready.
- Accept: in_fire = in_valid && in_ready. Output fire: out_fire = out_valid && out_ready.
- Main load condition: M_free = !out_valid || out_ready.
- Per rising edge, flush=0:
  - M_free && skid_full: M <- S, S cleared; if in_fire, input written into S (skid_full stays 1). Not reachable as in_ready=0 when skid_full; stated for completeness: S <- input.
  - M_free && !skid_full: M <- input if in_fire, else M becomes bubble (out_valid=0).
  - !M_free && in_fire: S <- input, skid_full=1.
  - !M_free && !in_fire: hold.
- Latency: accepted input appears on *_out the next cycle when MEM not stalled; with stall, order strictly preserved (M before S).
- Bubble rule: whenever out_valid is 0 after an edge, WB_out and M_out are 0; data fields (ALU_result, ALU_src2, ALU_zero, PC, REG_dst) hold their last values. Same rule for S contents when skid_full=0.
- Flush=1 at an edge: out_valid=0, skid_full=0, WB_out=0, M_out=0, in_ready=1 next cycle; input presented in the flush cycle is discarded even if in_fire. Flush overrides all other updates; out_fire in the same cycle still counts as consumed by MEM.
- Throughput: one instruction per cycle sustained when out_ready=1; single-cycle out_ready deassert absorbed by S without dropping in_ready in that same cycle.
- No widths truncated or extended; fields are copied bit-exact.

Test Plan:
- Reset: drive rst=0 mid-stream with out_valid=1, skid_full=1 -> immediately out_valid=0, skid_full=0, in_ready=1, all outputs 0.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with ALU_result_in=0x10,0x20,0x30,0x40 -> ALU_result_out shows 0x10..0x40 one cycle later, out_valid=1 each cycle, skid_full never set.
- Stall/skid: M holds 0xA, out_ready=0, input 0xB accepted -> skid_full=1, in_ready=0 next cycle, output held 0xA; raise out_ready -> 0xA consumed, 0xB appears next cycle, skid_full=0, in_ready=1.
- Bubble: in_valid=0 with out_ready=1 after WB_in=2'b11, M_in=3'b010 passed through -> out_valid=0, WB_out=0, M_out=0, ALU_result_out unchanged.
- Flush: out_valid=1, skid_full=1, in_valid=1 with PC_in=0x100, flush=1 -> next cycle out_valid=0, skid_full=0, WB_out=0, M_out=0, PC 0x100 never appears on PC_out.
- Parameters: DATA_BITS=64, REG_ADDR_BITS=6 -> ALU_result_in=0xFFFF_0000_1234_5678, REG_dst_in=6'd63 reproduced exactly on outputs.
